// File: rtl/ram_stream_reader.sv
// Streams a burst of bytes from a 4096x8 single-clock RAM through a 2-entry FIFO to a valid/ready consumer.
// Optional feature macro: RAM_STREAM_CHECKSUM_EN enables the running modulo-256 byte sum on checksum.
module ram_stream_reader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] base_addr,
  input  logic [12:0] length,
  output logic [11:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [12:0] remaining_q, remaining_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [7:0]  fifo_q [2];
  logic        push, pop, issue;
  logic [2:0]  occupancy;

  assign rd_addr = addr_q;
  assign m_valid = (count_q != 2'd0);
  assign m_data  = fifo_q[rd_ptr_q];
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);

  // A read is only issued if its data is guaranteed a FIFO slot on arrival,
  // counting entries already stored, the read in flight and this cycle's pop.
  always_comb begin
    pop         = m_valid && m_ready;
    push        = inflight_q;
    occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue       = (state_q == STREAM) && (remaining_q != 13'd0) && (occupancy < 3'd2);
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    inflight_d  = issue;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    state_d     = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = length;
          if (length == 13'd0) state_d = FIN;
          else                 state_d = STREAM;
        end
      end
      STREAM: begin
        if (issue) begin
          addr_d      = addr_q + 12'd1;
          remaining_d = remaining_q - 13'd1;
          if (remaining_q == 13'd1) state_d = DRAIN;
        end
      end
      // Finish as soon as the last byte leaves, so done lands the cycle after it.
      DRAIN: begin
        if (!inflight_q && (count_d == 2'd0)) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 12'd0;
      remaining_q <= 13'd0;
      inflight_q  <= 1'b0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_q ^ push;
      rd_ptr_q    <= rd_ptr_q ^ pop;
      if (push) fifo_q[wr_ptr_q] <= rd_data;
    end
  end

`ifdef RAM_STREAM_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;
  logic       accept;

  always_comb begin
    accept     = (state_q == IDLE) && start;
    checksum_d = checksum_q;
    if (accept)   checksum_d = 8'd0;
    else if (pop) checksum_d = checksum_q + m_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) checksum_q <= 8'd0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 Port rst_n, input, 1: synchronous, active-low reset.
REQ-003 Port start, input, 1: request a burst; sampled only in IDLE.
REQ-004 Port base_addr, input, 12: first RAM address of the burst; sampled with start.
REQ-005 Port length, input, 13: byte count, 0..4096; sampled with start.
REQ-006 Port rd_addr, output, 12: read address to the 4096x8 single-clock RAM; driven directly from the internal address register.
REQ-007 Port rd_data, input, 8: RAM q; valid on the edge after rd_addr was sampled by the RAM.
REQ-008 Port m_data, output, 8: stream byte to the downstream consumer.
REQ-009 Port m_valid, output, 1: m_data holds a valid byte.
REQ-010 Port m_ready, input, 1: consumer accepts; a transfer occurs on an edge where m_valid && m_ready.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port checksum, output, 8: burst byte sum; see REQ-030/031.

Function
REQ-014 The state machine SHALL have states IDLE, STREAM, DRAIN and FIN.
- IDLE->STREAM on start with length!=0.
- IDLE->FIN on start with length==0.
- STREAM->DRAIN when the last read is issued.
- DRAIN->FIN when inflight==0 and the FIFO is empty.
- FIN->IDLE unconditionally.
REQ-015 done SHALL be 1 only in FIN.
- Nonzero burst: the cycle after the final transfer.
- length==0: the cycle after start; no bytes emitted.
REQ-016 A read issue SHALL occur in STREAM when remaining>0 and (fifo_count + inflight - pop) < 2.
- pop = m_valid && m_ready in that cycle.
- On issue: rd_addr advances by 1, remaining decrements by 1, inflight is set to 1.
REQ-017 On the edge after an issue, rd_data SHALL be written into a 2-entry FIFO.
- The FIFO SHALL never overflow.
- Push and pop in the same cycle SHALL both take effect.
REQ-018 m_data/m_valid SHALL reflect the FIFO head.
- m_valid = (fifo_count != 0).
- m_data SHALL stay stable while m_valid && !m_ready.
REQ-019 Addresses SHALL be base_addr + i modulo 4096; 0xFFF wraps to 0x000.
REQ-020 Bytes SHALL be emitted in address order, exactly length bytes per burst.
REQ-021 With m_ready held high, throughput SHALL be 1 byte/cycle after a 2-cycle start latency.
- First m_valid = 2 cycles after start is sampled.
REQ-022 start SHALL be ignored outside IDLE; it SHALL NOT restart or extend a burst.
REQ-023 rd_addr SHALL hold its last value when no issue occurs.
REQ-024 m_ready low for any duration SHALL cause no byte loss and no duplication.

Reset
REQ-025 rst_n low at an edge SHALL force the following, regardless of state, including mid-burst:
- state=IDLE, rd_addr=0, m_valid=0, m_data=0
- busy=0, done=0, checksum=0
- FIFO and inflight cleared
REQ-026 After reset release, an interrupted burst SHALL NOT resume and SHALL NOT produce done.
REQ-027 start asserted in the same cycle as rst_n low SHALL be ignored.

Configuration
REQ-028 Macro RAM_STREAM_CHECKSUM_EN SHALL select checksum generation.
REQ-029 Port checksum SHALL exist in both builds.
REQ-030 With RAM_STREAM_CHECKSUM_EN defined:
- checksum clears to 0 on accepted start.
- checksum adds each transferred byte modulo 256.
- The final value is valid in the cycle done=1 and holds until the next accepted start.
REQ-031 Without RAM_STREAM_CHECKSUM_EN: checksum SHALL be constant 0 and no adder logic SHALL be synthesized.

Verification
REQ-032 Basic burst: RAM mem[i]=i[7:0]; base=0x010, length=4, m_ready=1 -> bytes 10,11,12,13 on consecutive cycles; done 1 cycle after the last; checksum=0x46 (EN build).
REQ-033 Wrap: base=0xFFE, length=4 -> rd_addr sequence FFE,FFF,000,001; bytes FE,FF,00,01.
REQ-034 Backpressure: length=8; m_ready toggles 1,0,0,1,... -> exactly 8 transfers, in order, no duplicates; m_data stable while stalled.
REQ-035 Zero length and start while busy: start with length=0 -> done next cycle, m_valid never 1; start pulsed mid-burst -> ignored, byte count unchanged.
REQ-036 Reset mid-burst: rst_n low after 3 of 10 bytes -> next cycle busy=0, m_valid=0, checksum=0; no done afterward.
REQ-037 Build check: without RAM_STREAM_CHECKSUM_EN, REQ-032 stimulus -> checksum=0 throughout.
